// File: rtl/regfile_mp_sb.sv
// Two-read/one-write register file with byte enables, an optional hardwired zero
// register and a per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_busy_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_busy_b,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                pend_set,
  input  logic [ADDR_W-1:0]   pend_addr,
  output logic [DEPTH-1:0]    pend_vec
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_ok;
  logic              set_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Write value: new lanes where enabled, current register contents elsewhere.
  always_comb begin
    wr_merged = regs_q[wr_addr];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) begin
        wr_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  assign wr_ok  = wr_en && !is_zero(wr_addr);
  assign set_ok = pend_set && !is_zero(pend_addr);

  // A write retires the pending flag even with no lanes enabled; a same-address set wins.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_merged;
      pend_d[wr_addr] = 1'b0;
    end
    if (set_ok) begin
      pend_d[pend_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = pend_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = pend_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Bypassed busy reflects only a set landing on the same edge as the write.
    if (wr_en && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_merged;
      rd_busy_a = pend_set && (pend_addr == rd_addr_a);
    end
    if (wr_en && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_merged;
      rd_busy_b = pend_set && (pend_addr == rd_addr_b);
    end
`endif
    if (is_zero(rd_addr_a)) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
    if (is_zero(rd_addr_b)) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a default 32x32 instance and a 64-bit x 16 instance.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, pend_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data, pend_vec;
  logic        rd_busy_a, rd_busy_b, wr_en, pend_set;
  logic [3:0]  wr_be;

  logic [3:0]  w_rd_addr_a, w_rd_addr_b, w_wr_addr, w_pend_addr;
  logic [63:0] w_rd_data_a, w_rd_data_b, w_wr_data;
  logic        w_rd_busy_a, w_rd_busy_b, w_wr_en, w_pend_set;
  logic [7:0]  w_wr_be;
  logic [15:0] w_pend_vec;

  regfile_mp_sb u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_vec(pend_vec)
  );

  regfile_mp_sb #(.DATA_W(64), .DEPTH(16)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(w_rd_addr_a), .rd_data_a(w_rd_data_a), .rd_busy_a(w_rd_busy_a),
    .rd_addr_b(w_rd_addr_b), .rd_data_b(w_rd_data_b), .rd_busy_b(w_rd_busy_b),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .wr_be(w_wr_be),
    .pend_set(w_pend_set), .pend_addr(w_pend_addr), .pend_vec(w_pend_vec)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  sb_t e;
  int  checks = 0;
  int  errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ps;
    logic [4:0]  pa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] xa;
    logic        xba;
    logic [31:0] xb;
    logic        xbb;
    logic [31:0] xpv;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [63:0] actual(input int kind);
    case (kind)
      0: return {32'h0, rd_data_a};
      1: return {63'h0, rd_busy_a};
      2: return {32'h0, rd_data_b};
      3: return {63'h0, rd_busy_b};
      4: return {32'h0, pend_vec};
      5: return w_rd_data_a;
      6: return {63'h0, w_rd_busy_a};
      default: return {48'h0, w_pend_vec};
    endcase
  endfunction

  // Expectations pushed while driving a cycle are compared at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (actual(e.kind) !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, actual(e.kind), e.exp, cyc);
      end
    end
  end

  task automatic push_exp(input int kind, input logic [63:0] v, input string name);
    sb_t x;
    x.due = cyc; x.kind = kind; x.exp = v; x.name = name;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    pend_set = 1'b0; pend_addr = '0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_wr_be = '0;
    w_pend_set = 1'b0; w_pend_addr = '0;
  endtask

  task automatic nwrite(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic wwrite(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d; w_wr_be = be;
  endtask

  initial begin
    // we wa wd be ps pa ra rb | xa xba xb xbb xpv  (reads observe state before the edge)
    vecs[0]  = '{1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd1, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd3, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0, 5'd4, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 5'd4, 32'h000000A5, 4'h1, 1'b1, 5'd7, 5'd3, 5'd5, 32'h11BB33DD, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd0, 5'd4, 5'd7, 32'h000000A5, 1'b0, 32'h0, 1'b1, 32'h80};
    vecs[4]  = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd7, 32'h11BB33DD, 1'b0, 32'h0, 1'b1, 32'h80};
    vecs[5]  = '{1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 5'd7, 5'd3, 5'd4, 32'h11BB33DD, 1'b0, 32'hA5, 1'b0, 32'h80};
    vecs[6]  = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd3, 32'h12345678, 1'b1, 32'h11BB33DD, 1'b0, 32'h80};
    vecs[7]  = '{1'b1, 5'd7, 32'h9ABCDEF0, 4'h3, 1'b0, 5'd0, 5'd3, 5'd4, 32'h11BB33DD, 1'b0, 32'hA5, 1'b0, 32'h80};
    vecs[8]  = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h1234DEF0, 1'b0, 32'h1234DEF0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd3, 5'd4, 32'h11BB33DD, 1'b0, 32'hA5, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    rst_n = 1'b0;
    idle();
    rd_addr_a = '0; rd_addr_b = '0; w_rd_addr_a = '0; w_rd_addr_b = '0;
    tick();
    tick();

    rst_n = 1'b1;
    rd_addr_a = 5'd5; rd_addr_b = 5'd31; w_rd_addr_a = 4'd15;
    push_exp(0, 64'h0, "reset_data_a");
    push_exp(1, 64'h0, "reset_busy_a");
    push_exp(2, 64'h0, "reset_data_b");
    push_exp(3, 64'h0, "reset_busy_b");
    push_exp(4, 64'h0, "reset_pend_vec");
    push_exp(7, 64'h0, "reset_wide_pend_vec");
    tick();

    for (int i = 0; i < 11; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_be = vecs[i].be;
      pend_set = vecs[i].ps; pend_addr = vecs[i].pa;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      push_exp(0, {32'h0, vecs[i].xa},  $sformatf("vec%0d_data_a", i));
      push_exp(1, {63'h0, vecs[i].xba}, $sformatf("vec%0d_busy_a", i));
      push_exp(2, {32'h0, vecs[i].xb},  $sformatf("vec%0d_data_b", i));
      push_exp(3, {63'h0, vecs[i].xbb}, $sformatf("vec%0d_busy_b", i));
      push_exp(4, {32'h0, vecs[i].xpv}, $sformatf("vec%0d_pend_vec", i));
      tick();
    end

    // Mid-stream reset discards the same-cycle write and set.
    idle();
    nwrite(5'd5, 32'hDEADBEEF, 4'hF); pend_set = 1'b1; pend_addr = 5'd5;
    rd_addr_a = 5'd1; rd_addr_b = 5'd2;
    tick();
    rst_n = 1'b0;
    nwrite(5'd6, 32'h12345678, 4'hF); pend_addr = 5'd6;
    rd_addr_a = 5'd5; rd_addr_b = 5'd0;
    push_exp(0, 64'hDEADBEEF, "prereset_data_r5");
    push_exp(1, 64'h1, "prereset_busy_r5");
    tick();
    rst_n = 1'b1;
    idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd6;
    push_exp(0, 64'h0, "postreset_data_r5");
    push_exp(1, 64'h0, "postreset_busy_r5");
    push_exp(2, 64'h0, "postreset_data_r6");
    push_exp(3, 64'h0, "postreset_busy_r6");
    push_exp(4, 64'h0, "postreset_pend_vec");
    tick();

    // Same-cycle read of the register being written.
    nwrite(5'd9, 32'h55550000, 4'hF); pend_set = 1'b1; pend_addr = 5'd9;
    rd_addr_a = 5'd1; rd_addr_b = 5'd1;
    tick();
    idle();
    nwrite(5'd9, 32'hCAFEF00D, 4'hF);
    rd_addr_a = 5'd9; rd_addr_b = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push_exp(0, 64'hCAFEF00D, "bypass_data_a");
    push_exp(1, 64'h0, "bypass_busy_a");
    push_exp(2, 64'hCAFEF00D, "bypass_data_b");
    push_exp(3, 64'h0, "bypass_busy_b");
`else
    push_exp(0, 64'h55550000, "samecycle_data_a");
    push_exp(1, 64'h1, "samecycle_busy_a");
    push_exp(2, 64'h55550000, "samecycle_data_b");
    push_exp(3, 64'h1, "samecycle_busy_b");
`endif
    tick();
    idle();
    push_exp(0, 64'hCAFEF00D, "after_write_data_a");
    push_exp(1, 64'h0, "after_write_busy_a");
    tick();

    // Wide instance: byte merge over eight lanes, scoreboard on the top address.
    wwrite(4'd3, 64'h1122334455667788, 8'hFF);
    tick();
    wwrite(4'd3, 64'hAABBCCDDEEFF0011, 8'h55);
    tick();
    wwrite(4'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    tick();
    idle();
    w_rd_addr_a = 4'd3; w_pend_set = 1'b1; w_pend_addr = 4'd15;
    push_exp(5, 64'h11BB33DD55FF7711, "wide_merge_data");
    push_exp(6, 64'h0, "wide_merge_busy");
    tick();
    idle();
    w_rd_addr_a = 4'd15;
    push_exp(5, 64'h0, "wide_r15_data_pending");
    push_exp(6, 64'h1, "wide_r15_busy_set");
    push_exp(7, 64'h8000, "wide_pend_vec_set");
    tick();
    wwrite(4'd15, 64'h0123456789ABCDEF, 8'hFF); w_pend_set = 1'b1; w_pend_addr = 4'd15;
    w_rd_addr_a = 4'd3;
    push_exp(5, 64'h11BB33DD55FF7711, "wide_be0_hold");
    tick();
    idle();
    w_rd_addr_a = 4'd15;
    push_exp(5, 64'h0123456789ABCDEF, "wide_r15_data");
    push_exp(6, 64'h1, "wide_r15_busy_set_wins");
    push_exp(7, 64'h8000, "wide_pend_vec_set_wins");
    tick();
    wwrite(4'd15, 64'h0, 8'h00);
    w_rd_addr_a = 4'd3;
    tick();
    idle();
    w_rd_addr_a = 4'd15;
    push_exp(5, 64'h0123456789ABCDEF, "wide_r15_be0_data");
    push_exp(6, 64'h0, "wide_r15_busy_cleared");
    push_exp(7, 64'h0, "wide_pend_vec_cleared");
    tick();

    for (int k = 0; k < 5 && sb.size() != 0; k++) tick();

    idle();
    rd_addr_a = 5'd9; rd_addr_b = 5'd0; w_rd_addr_a = 4'd3;
    #1;
    checks++;
    if (rd_data_a !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL final_r9_data: got %h", rd_data_a);
    end
    checks++;
    if (rd_busy_a !== 1'b0) begin
      errors++;
      $display("FAIL final_r9_busy: got %b", rd_busy_a);
    end
    checks++;
    if (rd_data_b !== 32'h0 || rd_busy_b !== 1'b0) begin
      errors++;
      $display("FAIL final_r0: got %h busy %b", rd_data_b, rd_busy_b);
    end
    checks++;
    if (pend_vec !== 32'h0) begin
      errors++;
      $display("FAIL final_pend_vec: got %h", pend_vec);
    end
    checks++;
    if (w_rd_data_a !== 64'h11BB33DD55FF7711) begin
      errors++;
      $display("FAIL final_wide_r3: got %h", w_rd_data_a);
    end
    checks++;
    if (w_pend_vec !== 16'h0) begin
      errors++;
      $display("FAIL final_wide_pend_vec: got %h", w_pend_vec);
    end

    while (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no comparison expected %h", e.name, e.exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
# regfile_mp_sb

Parametrised two-read/one-write register file with per-byte write enables, a hardwired zero register, and a per-register pending-write scoreboard. It replaces the file-backed register block in the single-cycle datapath. Storage is a clocked flop array with no file I/O. Decode uses it for operand fetch, writeback for result commit, and the hazard logic uses its busy flags to stall on outstanding loads.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8
- DEPTH, 32, number of registers; must be a power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), register address width
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes and pending sets

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- rd_addr_a  input  ADDR_W  read port A address
- rd_data_a  output  DATA_W  read port A data, combinational
- rd_busy_a  output  1  register at rd_addr_a has a pending write
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_b  output  DATA_W  read port B data, combinational
- rd_busy_b  output  1  register at rd_addr_b has a pending write
- wr_en  input  1  write strobe
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_be  input  DATA_W/8  byte enables; bit i selects wr_data[8i+7:8i]
- pend_set  input  1  mark pend_addr as awaiting a write
- pend_addr  input  ADDR_W  register to mark pending
- pend_vec  output  DEPTH  scoreboard bit per register

## Operation
- Storage is DEPTH × DATA_W flops.
- Write: on a clk edge with rst_n=1 and wr_en=1:
  - byte lane i of reg[wr_addr] takes wr_data lane i if wr_be[i]=1; otherwise the lane holds.
  - wr_be = 0 leaves the register unchanged.
  - The write clears pend_vec[wr_addr] even when wr_be = 0.
- pend_set=1 sets pend_vec[pend_addr].
- Simultaneous set and clear on the same address: set wins. This models back-to-back loads to the same destination.
- Reads: rd_data_x = reg[rd_addr_x]; rd_busy_x = pend_vec[rd_addr_x]. Both ports are independent, and the same address may be read on both.
- ZERO_REG=1: address 0 reads 0 with busy 0; writes and pend_set to address 0 are dropped.
- There is no X filtering. The write is committed as presented.

## Timing
- Reset: when rst_n=0 at a clk edge, every register and every pend_vec bit clears to 0. Write and pend_set inputs are ignored in that cycle.
- After reset, all rd_data are 0 and all busy flags are 0.
- Reset asserted mid-stream discards any same-cycle write or set. There is no partial commit.
- Write latency: data is visible on the read ports the cycle after the edge that commits it, unless bypass is enabled (see Configuration).
- Scoreboard latency: a set or clear is visible on pend_vec and the busy flags after the committing edge.
- Reads are purely combinational from address to data, with no state on the read path.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address equals wr_addr while wr_en=1 returns the merged value: wr_data lanes where wr_be=1, current register lanes elsewhere.
  - rd_busy for that address reads 0 unless pend_set targets the same address in the same cycle.
  - ZERO_REG masking still applies to bypassed reads.
- REGFILE_BYPASS_EN undefined:
  - Same-cycle reads return the pre-write value.
  - Busy reflects the registered pend_vec only.

## Test plan
- Reset clear: write 0xDEADBEEF to r5 → assert rst_n=0 for one edge → rd_data_a(r5)=0 and pend_vec=0.
- Byte merge: write 0x11223344 (wr_be=4'hF) to r3 → write 0xAABBCCDD with wr_be=4'b0101 → r3 reads 0x11BB33DD. A following write with wr_be=0 leaves r3 = 0x11BB33DD.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF and pend_set to r0 → rd_data_b(r0)=0, rd_busy_b=0, pend_vec[0]=0.
- Scoreboard: pend_set r7 → rd_busy_a(r7)=1 next cycle. Then assert wr_en to r7 together with pend_set r7 → busy stays 1. Then wr_en alone → busy=0.
- Bypass: with wr_en to r9 of 0xCAFEF00D and rd_addr_a=r9 in the same cycle:
  - macro defined: rd_data_a=0xCAFEF00D that cycle.
  - macro undefined: old value that cycle, 0xCAFEF00D the next.
- Width/depth sweep: DATA_W=64, DEPTH=16 → the byte-merge and scoreboard scenarios pass with an 8-bit wr_be and a 4-bit address.
